// File: rtl/man_div_seq.sv
// Sequential mantissa divider: truncated 1.Xm / 1.Ym, radix-2 restoring, one quotient bit per clock.
// Latency: start accepted at edge t, done pulses in the cycle after edge t+9; busy spans CALC and DONE.
// Backpressure: none; start is only sampled in IDLE, requests during CALC/DONE are dropped.
module man_div_seq #(
    parameter int MW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [MW-1:0] Xm,
    input  logic [MW-1:0] Ym,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] Zm,
    output logic          QLT1,
    output logic          INEX
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Final step is taken when the counter has already counted MW+1 steps.
    localparam logic [3:0] LAST = 4'(MW + 1);

    state_t         state_q;
    logic [MW:0]    d_q;       // divisor with hidden one
    logic [MW+1:0]  r_q;       // partial remainder, always < 2*D
    logic [MW+1:0]  q_q;       // quotient shift register, MSB is the integer bit
    logic [3:0]     cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [MW-1:0]  zm_q;
    logic           qlt1_q;
    logic           inex_q;

    logic           ge;
    logic [MW+1:0]  diff;
    logic [MW+1:0]  r_sel;
    logic [MW+1:0]  r_d;
    logic [MW+1:0]  q_d;

    // One restoring-division step: trial subtract, keep the difference if non-negative, then shift.
    always_comb begin
        ge    = 1'b0;
        diff  = '0;
        r_sel = '0;
        r_d   = '0;
        q_d   = '0;
        ge    = (r_q >= {1'b0, d_q});
        diff  = r_q - {1'b0, d_q};
        r_sel = ge ? diff : r_q;
        r_d   = r_sel << 1;
        q_d   = (q_q << 1) | {{(MW+1){1'b0}}, ge};
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zm_q    <= '0;
            qlt1_q  <= 1'b0;
            inex_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        d_q     <= {1'b1, Ym};
                        r_q     <= {2'b01, Xm};
                        q_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        // Normalise: an integer bit of 1 means quotient in [1,2); otherwise
                        // it is in (0.5,1) and the next bit down is the leading one.
                        if (q_d[MW+1]) begin
                            zm_q   <= q_d[MW:1];
                            qlt1_q <= 1'b0;
                        end else begin
                            zm_q   <= q_d[MW-1:0];
                            qlt1_q <= 1'b1;
                        end
                        // Inexact if bits were lost either in the remainder or by dropping Q[0].
                        inex_q  <= (r_d != '0) || (q_d[MW+1] && q_d[0]);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Zm   = zm_q;
    assign QLT1 = qlt1_q;
    assign INEX = inex_q;

endmodule

// File: tb/tb_man_div_seq.sv
// Bench for man_div_seq: directed operand pairs with hand-computed quotients.
// Driver pushes expected results (value and completion edge) into a queue; a monitor checks each done.
// Also covers held start, reset mid-operation and busy/done timing.
module tb_man_div_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] Xm;
    logic [6:0] Ym;
    logic       busy;
    logic       done;
    logic [6:0] Zm;
    logic       QLT1;
    logic       INEX;

    typedef struct {
        logic [6:0] zm;
        logic       qlt1;
        logic       inex;
        int         edge_no;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   cyc;

    man_div_seq #(.MW(7)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Xm    (Xm),
        .Ym    (Ym),
        .busy  (busy),
        .done  (done),
        .Zm    (Zm),
        .QLT1  (QLT1),
        .INEX  (INEX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after edge k (and until edge k+1) cyc == k.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation, including its edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                total = total + 1;
                if (sb.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_done: got done at edge %0d Zm=%h QLT1=%0d INEX=%0d, expected no done",
                             cyc, Zm, QLT1, INEX);
                end else begin
                    e = sb.pop_front();
                    if (Zm !== e.zm || QLT1 !== e.qlt1 || INEX !== e.inex || cyc != e.edge_no) begin
                        bad = bad + 1;
                        $display("FAIL %s: got Zm=%h QLT1=%0d INEX=%0d edge=%0d, expected Zm=%h QLT1=%0d INEX=%0d edge=%0d",
                                 e.name, Zm, QLT1, INEX, cyc, e.zm, e.qlt1, e.inex, e.edge_no);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // One complete division: pulse start, expect done 9 edges after the accepting edge,
    // busy high for 10 cycles, and idle in the cycle after done.
    task automatic do_op(input logic [6:0] x, input logic [6:0] y,
                         input logic [6:0] ez, input logic eq, input logic ei,
                         input string name);
        int busy_cnt;
        bit seen;
        exp_t e;
        @(negedge clk);
        Xm    = x;
        Ym    = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.zm = ez; e.qlt1 = eq; e.inex = ei; e.edge_no = cyc + 9; e.name = name;
        sb.push_back(e);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_busy_cycles"}, busy_cnt, 32'd10);
        @(negedge clk);
        check({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   k;
        int   dones;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        Xm    = 7'h00;
        Ym    = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {20'd0, busy, done, Zm, QLT1, INEX}, 32'd0);
        rst = 1'b0;

        // Directed vectors: Q = floor(256 * 1.X / 1.Y)
        do_op(7'h00, 7'h00, 7'h00, 1'b0, 1'b0, "one_div_one");   // Q=0x100
        do_op(7'h40, 7'h00, 7'h40, 1'b0, 1'b0, "1p5_div_1");     // Q=0x180
        do_op(7'h00, 7'h40, 7'h2A, 1'b1, 1'b1, "1_div_1p5");     // Q=0x0AA
        do_op(7'h7F, 7'h00, 7'h7F, 1'b0, 1'b0, "max_div_1");     // Q=0x1FE
        do_op(7'h00, 7'h7F, 7'h00, 1'b1, 1'b1, "1_div_max");     // Q=0x080
        do_op(7'h7F, 7'h7F, 7'h00, 1'b0, 1'b0, "max_div_max");   // Q=0x100
        do_op(7'h01, 7'h00, 7'h01, 1'b0, 1'b0, "x01_div_1");     // Q=0x102
        do_op(7'h7F, 7'h01, 7'h7D, 1'b0, 1'b1, "max_div_x01");   // Q=0x1FA, rem!=0

        // Start held high across a whole operation with operands changing after capture.
        // First op uses 0x40/0x00; start is ignored in CALC and DONE, so the second op is
        // accepted in IDLE two edges after the done edge and uses the new operands.
        @(negedge clk);
        Xm    = 7'h40;
        Ym    = 7'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        e.zm = 7'h40; e.qlt1 = 1'b0; e.inex = 1'b0; e.edge_no = k + 9;  e.name = "held_first";
        sb.push_back(e);
        e.zm = 7'h2A; e.qlt1 = 1'b1; e.inex = 1'b1; e.edge_no = k + 20; e.name = "held_second";
        sb.push_back(e);
        Xm = 7'h00;
        Ym = 7'h40;
        dones = 0;
        while (cyc < k + 11) begin
            @(negedge clk);
            if (done) dones++;
        end
        #1;
        start = 1'b0;
        Xm    = 7'h7F;
        Ym    = 7'h7F;
        check("held_single_done", dones, 32'd1);
        while (cyc < k + 23) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("held_total_dones", dones, 32'd2);

        // Reset during the 5th CALC cycle aborts with no done and clears outputs.
        @(negedge clk);
        Xm    = 7'h7F;
        Ym    = 7'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = cyc;
        while (cyc < k + 4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {20'd0, busy, done, Zm, QLT1, INEX}, 32'd0);
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("aborted_no_done", dones, 32'd0);
        do_op(7'h7F, 7'h01, 7'h7D, 1'b0, 1'b1, "after_reset");
        do_op(7'h00, 7'h40, 7'h2A, 1'b1, 1'b1, "after_reset2");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
